// File: rtl/res_shortcut_add.sv
// Stride-2 residual shortcut: 2x2 average-pools residual windows into a FIFO,
// then adds each queued shortcut to the matching conv result (saturate, optional ReLU).
module res_shortcut_add #(
  parameter int FM_DEPTH   = 64,
  parameter int FM_WIDTH   = 56,
  parameter int FIFO_DEPTH = 4,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode_in,
  input  logic                             verticle_sync,
  input  logic                             res_valid,
  input  logic [FM_DEPTH-1:0][3:0][15:0]   res_in,
  input  logic                             macro_valid,
  input  logic [FM_DEPTH-1:0][15:0]        macro_in,
  output logic                             out_valid,
  output logic [FM_DEPTH-1:0][15:0]        out_data,
  output logic                             frame_done,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_PIX = (FM_WIDTH / 2) * (FM_WIDTH / 2);
  localparam int OCW       = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  // Floor average of four signed samples; bits [17:2] of the 18-bit sum is sum >>> 2.
  function automatic logic [15:0] avg4(input logic [3:0][15:0] smp);
    logic [17:0] sum;
    sum = 18'd0;
    for (int k = 0; k < 4; k++) begin
      sum = sum + {{2{smp[k][15]}}, smp[k]};
    end
    return sum[17:2];
  endfunction

  function automatic logic [15:0] add_sat(input logic [15:0] a, input logic [15:0] b);
    logic [17:0] s;
    logic [15:0] r;
    s = {{2{a[15]}}, a} + {{2{b[15]}}, b};
    if (s[17] && (s[16:15] != 2'b11)) begin
      r = 16'h8000;
    end else if (!s[17] && (s[16:15] != 2'b00)) begin
      r = 16'h7FFF;
    end else begin
      r = s[15:0];
    end
    return (RELU_EN && r[15]) ? 16'h0000 : r;
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? AW'(0) : p + AW'(1);
  endfunction

  state_t                       r_state, w_state_nxt;
  logic [AW-1:0]                r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]                r_count, w_count_nxt;
  logic [FM_DEPTH-1:0][15:0]    r_mem [FIFO_DEPTH];
  logic [OCW-1:0]               r_out_cnt;
  logic                         r_out_valid, r_frame_done, r_overflow, r_underflow;
  logic [FM_DEPTH-1:0][15:0]    r_out_data;
  logic [FM_DEPTH-1:0][15:0]    w_avg, w_res, w_head;
  logic                         w_flush, w_run, w_push_req, w_pop_req;
  logic                         w_empty, w_full, w_push, w_pop, w_last_pix;

  assign w_flush    = !mode_in || verticle_sync;
  assign w_run      = (r_state == S_RUN) && !w_flush;
  assign w_push_req = w_run && res_valid;
  assign w_pop_req  = w_run && macro_valid;
  assign w_empty    = (r_count == CW'(0));
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_pop      = w_pop_req && !w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_last_pix = (r_out_cnt == OCW'(FRAME_PIX - 1));
  assign w_head     = r_mem[r_rd_ptr];

  // Next-state logic; dropping mode_in wins over everything.
  always_comb begin
    w_state_nxt = r_state;
    if (!mode_in) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_WAIT_VS;
        S_WAIT_VS: w_state_nxt = verticle_sync ? S_RUN : S_WAIT_VS;
        S_RUN:     w_state_nxt = S_RUN;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Per-channel pooling of the incoming window and shortcut addition at the head.
  always_comb begin
    w_avg = '0;
    w_res = '0;
    for (int c = 0; c < FM_DEPTH; c++) begin
      w_avg[c] = avg4(res_in[c]);
      w_res[c] = add_sat(macro_in[c], w_head[c]);
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Shortcut storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_avg;
    end
  end

  // State, FIFO control, output register and frame bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_flush) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_out_cnt    <= '0;
        r_out_valid  <= 1'b0;
        r_out_data   <= '0;
        r_frame_done <= 1'b0;
        r_overflow   <= 1'b0;
        r_underflow  <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr   <= ptr_inc(r_rd_ptr);
          r_out_data <= w_res;
          r_out_cnt  <= w_last_pix ? OCW'(0) : r_out_cnt + OCW'(1);
        end
        r_count      <= w_count_nxt;
        r_out_valid  <= w_pop;
        r_frame_done <= w_pop && w_last_pix;
        if (w_push_req && w_full && !w_pop) begin
          r_overflow <= 1'b1;
        end
        if (w_pop_req && w_empty) begin
          r_underflow <= 1'b1;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_res_shortcut_add.sv
// Bench for res_shortcut_add: two instances (ReLU on/off) on shared stimulus,
// table vectors plus hand sequences, checked through an expected-output queue.
module tb_res_shortcut_add;

  localparam int FMD   = 4;
  localparam int FMW   = 8;
  localparam int FD    = 4;
  localparam int FRAME = (FMW / 2) * (FMW / 2);

  typedef logic [FMD-1:0][15:0]      chvec_t;
  typedef logic [FMD-1:0][3:0][15:0] resvec_t;
  typedef struct packed { chvec_t d_rel; chvec_t d_lin; logic fd; } exp_t;
  typedef struct {
    logic [15:0] s0, s1, s2, s3;
    logic [15:0] mac, e_rel, e_lin;
  } vec_t;

  logic clk, rst, mode_in, verticle_sync, res_valid, macro_valid;
  resvec_t res_in;
  chvec_t  macro_in;
  logic    ov_a, fd_a, of_a, uf_a, ov_b, fd_b, of_b, uf_b;
  chvec_t  od_a, od_b;
  logic [2:0] fc_a, fc_b;

  res_shortcut_add #(.FM_DEPTH(FMD), .FM_WIDTH(FMW), .FIFO_DEPTH(FD), .RELU_EN(1'b1)) u_relu (
    .clk(clk), .rst(rst), .mode_in(mode_in), .verticle_sync(verticle_sync),
    .res_valid(res_valid), .res_in(res_in), .macro_valid(macro_valid), .macro_in(macro_in),
    .out_valid(ov_a), .out_data(od_a), .frame_done(fd_a), .fifo_count(fc_a),
    .overflow(of_a), .underflow(uf_a));

  res_shortcut_add #(.FM_DEPTH(FMD), .FM_WIDTH(FMW), .FIFO_DEPTH(FD), .RELU_EN(1'b0)) u_lin (
    .clk(clk), .rst(rst), .mode_in(mode_in), .verticle_sync(verticle_sync),
    .res_valid(res_valid), .res_in(res_in), .macro_valid(macro_valid), .macro_in(macro_in),
    .out_valid(ov_b), .out_data(od_b), .frame_done(fd_b), .fifo_count(fc_b),
    .overflow(of_b), .underflow(uf_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     fd_seen = 0;
  int     mdl_state = 0;
  int     mdl_cnt = 0;
  logic   mdl_of = 1'b0;
  logic   mdl_uf = 1'b0;
  chvec_t mdl_q[$];
  exp_t   exp_q[$];
  chvec_t last_rel = '0;
  chvec_t last_lin = '0;
  exp_t   mon_e;
  vec_t   tbl[7];

  task automatic chk(input string name, input bit ok, input string info);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  function automatic logic [15:0] ref_avg(input logic [3:0][15:0] smp);
    int sum, q;
    sum = 0;
    for (int k = 0; k < 4; k++) sum += int'($signed(smp[k]));
    q = sum / 4;
    if ((sum % 4) != 0 && sum < 0) q = q - 1;
    return 16'(q);
  endfunction

  function automatic logic [15:0] ref_out(input logic [15:0] avg, input logic [15:0] mac, input bit relu);
    int s;
    s = int'($signed(avg)) + int'($signed(mac));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return 16'(s);
  endfunction

  function automatic resvec_t uni(input logic [15:0] s0, s1, s2, s3);
    resvec_t v;
    for (int c = 0; c < FMD; c++) begin
      v[c][0] = s0; v[c][1] = s1; v[c][2] = s2; v[c][3] = s3;
    end
    return v;
  endfunction

  function automatic chvec_t cu(input logic [15:0] x);
    chvec_t v;
    for (int c = 0; c < FMD; c++) v[c] = x;
    return v;
  endfunction

  // Output monitor: every out_valid must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov_a || ov_b) begin
        if (!(ov_a && ov_b) || exp_q.size() == 0) begin
          chk("out_valid", 1'b0, $sformatf("got a=%0b b=%0b with %0d pending, expected no output", ov_a, ov_b, exp_q.size()));
        end else begin
          mon_e = exp_q.pop_front();
          if (fd_a) fd_seen++;
          chk("out_relu", od_a == mon_e.d_rel && fd_a == mon_e.fd,
              $sformatf("got data=%h fd=%0b expected data=%h fd=%0b", od_a, fd_a, mon_e.d_rel, mon_e.fd));
          chk("out_lin", od_b == mon_e.d_lin && fd_b == mon_e.fd,
              $sformatf("got data=%h fd=%0b expected data=%h fd=%0b", od_b, fd_b, mon_e.d_lin, mon_e.fd));
        end
      end else if (fd_a || fd_b) begin
        chk("frame_done", 1'b0, $sformatf("got fd a=%0b b=%0b without out_valid, expected 0", fd_a, fd_b));
      end
    end
  end

  // One clock of stimulus; the model predicts FIFO state and queues expected outputs.
  task automatic do_cycle(input logic m, input logic vs, input logic push, input resvec_t r,
                          input logic pop, input chvec_t mv, input bit has_exp,
                          input chvec_t erel, input chvec_t elin);
    chvec_t h, a, xr, xl;
    exp_t   e;
    logic   pop_ok;
    mode_in = m; verticle_sync = vs; res_valid = push; res_in = r;
    macro_valid = pop; macro_in = mv;
    if (!m || vs) begin
      mdl_q.delete(); mdl_of = 1'b0; mdl_uf = 1'b0; mdl_cnt = 0;
      last_rel = '0; last_lin = '0;
    end else if (mdl_state == 2) begin
      pop_ok = pop && (mdl_q.size() > 0);
      if (pop && !pop_ok) mdl_uf = 1'b1;
      if (pop_ok) begin
        h = mdl_q.pop_front();
        for (int c = 0; c < FMD; c++) begin
          xr[c] = ref_out(h[c], mv[c], 1'b1);
          xl[c] = ref_out(h[c], mv[c], 1'b0);
        end
        if (has_exp) begin xr = erel; xl = elin; end
        e.d_rel = xr; e.d_lin = xl;
        e.fd = (mdl_cnt == FRAME - 1);
        mdl_cnt = e.fd ? 0 : mdl_cnt + 1;
        exp_q.push_back(e);
        last_rel = xr; last_lin = xl;
      end
      if (push) begin
        for (int c = 0; c < FMD; c++) a[c] = ref_avg(r[c]);
        if (mdl_q.size() < FD) mdl_q.push_back(a);
        else mdl_of = 1'b1;
      end
    end
    if (!m) mdl_state = 0;
    else if (mdl_state == 0) mdl_state = 1;
    else if (mdl_state == 1) mdl_state = vs ? 2 : 1;
    else mdl_state = 2;
    @(negedge clk);
    #1;
    chk("latency", exp_q.size() == 0, $sformatf("got %0d outputs still pending, expected 0", exp_q.size()));
    chk("status_a", {fc_a, of_a, uf_a} == {3'(mdl_q.size()), mdl_of, mdl_uf},
        $sformatf("got cnt=%0d of=%0b uf=%0b expected cnt=%0d of=%0b uf=%0b", fc_a, of_a, uf_a, mdl_q.size(), mdl_of, mdl_uf));
    chk("status_b", {fc_b, of_b, uf_b} == {3'(mdl_q.size()), mdl_of, mdl_uf},
        $sformatf("got cnt=%0d of=%0b uf=%0b expected cnt=%0d of=%0b uf=%0b", fc_b, of_b, uf_b, mdl_q.size(), mdl_of, mdl_uf));
    chk("hold_data", od_a == last_rel && od_b == last_lin,
        $sformatf("got a=%h b=%h expected a=%h b=%h", od_a, od_b, last_rel, last_lin));
  endtask

  task automatic idle(input logic m, input logic vs);
    do_cycle(m, vs, 1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic push1(input resvec_t r);
    do_cycle(1'b1, 1'b0, 1'b1, r, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic pop1(input chvec_t mv);
    do_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, mv, 1'b0, '0, '0);
  endtask

  initial begin
    resvec_t r;
    chvec_t  mv;
    tbl[0] = '{16'd4, 16'd8, 16'd12, 16'd16, 16'd10, 16'd20, 16'd20};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'd1, 16'h0000, 16'hFFFF};
    tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbl[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h8000};
    tbl[4] = '{16'd100, 16'hFFCE, 16'd7, 16'd0, 16'hFF9C, 16'h0000, 16'hFFAA};
    tbl[5] = '{16'd3, 16'd0, 16'd0, 16'd0, 16'd5, 16'd5, 16'd5};
    tbl[6] = '{16'hFFFD, 16'd0, 16'd0, 16'd0, 16'd5, 16'd4, 16'd4};

    rst = 1'b1; mode_in = 1'b0; verticle_sync = 1'b0; res_valid = 1'b0;
    macro_valid = 1'b0; res_in = '0; macro_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", {ov_a, od_a, fd_a, fc_a, of_a, uf_a, ov_b, od_b, fd_b, fc_b, of_b, uf_b} == '0,
        $sformatf("got a: v=%0b d=%h fd=%0b c=%0d of=%0b uf=%0b expected all zero", ov_a, od_a, fd_a, fc_a, of_a, uf_a));
    rst = 1'b0;
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);

    // Table vectors: one push then one pop each, expected results from the table.
    for (int i = 0; i < 7; i++) begin
      push1(uni(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3));
      chk("tbl_push_count", fc_a == 3'd1, $sformatf("vec %0d got count=%0d expected 1", i, fc_a));
      do_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, cu(tbl[i].mac), 1'b1, cu(tbl[i].e_rel), cu(tbl[i].e_lin));
      idle(1'b1, 1'b0);
      chk("tbl_pulse", !ov_a && !ov_b && fc_a == 3'd0, $sformatf("vec %0d got v=%0b/%0b count=%0d expected 0/0 and 0", i, ov_a, ov_b, fc_a));
    end

    // Distinct values per channel.
    for (int c = 0; c < FMD; c++) begin
      for (int k = 0; k < 4; k++) r[c][k] = 16'(100 * (c + 1) + k);
      mv[c] = 16'(-3 * (c + 1));
    end
    push1(r);
    pop1(mv);

    // Overflow, then ordered drain.
    idle(1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      push1(uni(16'(1000 * i), 16'(1000 * i), 16'(1000 * i), 16'(1000 * i)));
    end
    chk("ovf_full", fc_a == 3'd4 && of_a == 1'b1 && of_b == 1'b1, $sformatf("got count=%0d of=%0b expected 4 and 1", fc_a, of_a));
    for (int i = 1; i <= 4; i++) pop1(cu(16'(i)));
    chk("ovf_drain", fc_a == 3'd0 && od_b == cu(16'd4004), $sformatf("got count=%0d data=%h expected 0 and 4004 per channel", fc_a, od_b));

    // Push and pop together while full: accepted, no overflow.
    idle(1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) push1(uni(16'(10 * i), 16'(10 * i), 16'(10 * i), 16'(10 * i)));
    do_cycle(1'b1, 1'b0, 1'b1, uni(16'd500, 16'd500, 16'd500, 16'd500), 1'b1, cu(16'd7), 1'b0, '0, '0);
    chk("full_pushpop", fc_a == 3'd4 && !of_a, $sformatf("got count=%0d of=%0b expected 4 and 0", fc_a, of_a));
    for (int i = 0; i < 4; i++) pop1(cu(16'(i)));

    // Underflow, empty push+pop, cleared by verticle_sync.
    pop1(cu(16'd1));
    chk("udf_set", uf_a && uf_b && !ov_a, $sformatf("got uf=%0b/%0b v=%0b expected 1/1 and 0", uf_a, uf_b, ov_a));
    do_cycle(1'b1, 1'b0, 1'b1, uni(16'd8, 16'd8, 16'd8, 16'd8), 1'b1, cu(16'd2), 1'b0, '0, '0);
    chk("empty_pushpop", fc_a == 3'd1 && !ov_a, $sformatf("got count=%0d v=%0b expected 1 and 0", fc_a, ov_a));
    idle(1'b1, 1'b1);
    chk("udf_clear", !uf_a && fc_a == 3'd0, $sformatf("got uf=%0b count=%0d expected 0 and 0", uf_a, fc_a));

    // Full frame of 16 outputs, then one more after the wrap.
    fd_seen = 0;
    for (int i = 0; i < FRAME + 1; i++) begin
      push1(uni(16'(i), 16'(2 * i), 16'(3 * i), 16'(4 * i)));
      pop1(cu(16'(i - 8)));
      if (i == FRAME - 1) chk("frame_done_16", fd_seen == 1, $sformatf("got %0d pulses expected 1", fd_seen));
    end
    chk("frame_done_wrap", fd_seen == 1, $sformatf("got %0d pulses expected 1", fd_seen));

    // mode_in drop mid-frame flushes; pushes ignored until the next verticle_sync.
    push1(uni(16'd40, 16'd40, 16'd40, 16'd40));
    do_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, cu(16'd5), 1'b0, '0, '0);
    chk("mode_drop", !ov_a && fc_a == 3'd0 && od_a == '0, $sformatf("got v=%0b count=%0d data=%h expected 0, 0, 0", ov_a, fc_a, od_a));
    push1(uni(16'd1, 16'd1, 16'd1, 16'd1));
    push1(uni(16'd1, 16'd1, 16'd1, 16'd1));
    chk("wait_ignore", fc_a == 3'd0, $sformatf("got count=%0d expected 0", fc_a));
    idle(1'b1, 1'b1);
    push1(uni(16'd12, 16'd12, 16'd12, 16'd12));
    chk("restart", fc_a == 3'd1, $sformatf("got count=%0d expected 1", fc_a));
    pop1(cu(16'd3));
    idle(1'b1, 1'b0);

    chk("drain", exp_q.size() == 0, $sformatf("got %0d pending expected 0", exp_q.size()));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
